// File: rtl/mha_fixp_pkg.sv
// Shared fixed-point definitions for the attention datapath arithmetic units.
// Holds the common FSM encoding and saturation bounds used by mul and div.
package mha_fixp_pkg;

    localparam int FRAC_W_DEF = 13;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_LOAD = 4'b0010,
        S_CALC = 4'b0100,
        S_END  = 4'b1000
    } fsm_state_t;

    function automatic logic [63:0] sat_max_mag(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min_mag(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fixp_sat_round.sv
// Shift, truncate toward zero, saturate and apply sign to a magnitude product.
// Purely combinational so any datapath block can reuse it.
module fixp_sat_round
    import mha_fixp_pkg::*;
#(
    parameter int D_W    = 16,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int ACC_W  = 2 * D_W
) (
    input  logic [ACC_W-1:0] acc,
    input  logic             neg,
    output logic [D_W-1:0]   res,
    output logic             ovf
);

    localparam int M_W = ACC_W - FRAC_W;
    localparam logic [M_W-1:0] MAX_M = M_W'(sat_max_mag(D_W));
    localparam logic [M_W-1:0] MIN_M = M_W'(sat_min_mag(D_W));

    logic [M_W-1:0] m;

    assign m = acc[ACC_W-1:FRAC_W];

    always_comb begin
        res = '0;
        ovf = 1'b0;
        // a zero magnitude never takes the negative path, so no -0
        if (m == '0) begin
            res = '0;
        end else if (!neg) begin
            if (m > MAX_M) begin
                res = D_W'(sat_max_mag(D_W));
                ovf = 1'b1;
            end else begin
                res = m[D_W-1:0];
            end
        end else begin
            if (m > MIN_M) begin
                res = D_W'(sat_min_mag(D_W));
                ovf = 1'b1;
            end else begin
                res = '0 - m[D_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mul_seq_fixp.sv
// Sequential shift-add signed fixed-point multiplier, one multiplier bit per cycle.
// START must stay high for the whole operation; dropping it aborts.
module mul_seq_fixp
    import mha_fixp_pkg::*;
#(
    parameter int D_W    = 16,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic           I_CLK,
    input  logic           I_RST,
    input  logic           I_MUL_START,
    input  logic [D_W-1:0] I_MULTIPLICAND,
    input  logic [D_W-1:0] I_MULTIPLIER,
    output logic [D_W-1:0] O_PRODUCT,
    output logic           O_OVF,
    output logic           O_OUT_VLD
);

    localparam int ACC_W = 2 * D_W;
    localparam int CNT_W = $clog2(D_W);

    fsm_state_t state, state_nxt;

    logic [D_W-1:0]   a_mag;
    logic [D_W-1:0]   b_mag;
    logic             neg;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic [D_W-1:0]   sat_res;
    logic             sat_ovf;

    function automatic logic [D_W-1:0] mag(input logic [D_W-1:0] v);
        return v[D_W-1] ? ('0 - v) : v;
    endfunction

    assign last      = (cnt == CNT_W'(D_W - 1));
    assign acc_nxt   = acc + (b_mag[cnt] ? (ACC_W'(a_mag) << cnt) : '0);
    assign O_OUT_VLD = (state == S_END);

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (I_MUL_START) state_nxt = S_LOAD;
            S_LOAD: state_nxt = I_MUL_START ? S_CALC : S_IDLE;
            S_CALC: begin
                if (!I_MUL_START) state_nxt = S_IDLE;
                else if (last)    state_nxt = S_END;
            end
            S_END:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            a_mag     <= '0;
            b_mag     <= '0;
            neg       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            O_PRODUCT <= '0;
            O_OVF     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    acc <= '0;
                    cnt <= '0;
                end
                S_LOAD: begin
                    if (I_MUL_START) begin
                        a_mag <= mag(I_MULTIPLICAND);
                        b_mag <= mag(I_MULTIPLIER);
                        neg   <= I_MULTIPLICAND[D_W-1] ^ I_MULTIPLIER[D_W-1];
                    end
                end
                S_CALC: begin
                    // the final step writes the result from the updated sum
                    if (I_MUL_START) begin
                        acc <= acc_nxt;
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            O_PRODUCT <= sat_res;
                            O_OVF     <= sat_ovf;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    fixp_sat_round #(
        .D_W    (D_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_sat (
        .acc (acc_nxt),
        .neg (neg),
        .res (sat_res),
        .ovf (sat_ovf)
    );

endmodule

// File: tb/tb_mul_seq_fixp.sv
// Scoreboard bench for mul_seq_fixp (D_W=16, FRAC_W=13).
// Expected products come from a table or an integer reference model.
module tb_mul_seq_fixp;
    import mha_fixp_pkg::*;

    logic        I_CLK;
    logic        I_RST;
    logic        I_MUL_START;
    logic [15:0] I_MULTIPLICAND;
    logic [15:0] I_MULTIPLIER;
    logic [15:0] O_PRODUCT;
    logic        O_OVF;
    logic        O_OUT_VLD;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        logic        o;
    } op_t;

    op_t pend[$];
    op_t sb[$];
    op_t mon_e;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int vld_n = 0;

    logic [15:0] last_p = '0;
    logic        last_o = 1'b0;

    mul_seq_fixp #(
        .D_W    (16),
        .FRAC_W (13)
    ) dut (
        .I_CLK          (I_CLK),
        .I_RST          (I_RST),
        .I_MUL_START    (I_MUL_START),
        .I_MULTIPLICAND (I_MULTIPLICAND),
        .I_MULTIPLIER   (I_MULTIPLIER),
        .O_PRODUCT      (O_PRODUCT),
        .O_OVF          (O_OVF),
        .O_OUT_VLD      (O_OUT_VLD)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    always @(posedge I_CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] a,
                                          input logic [15:0] b);
        longint p;
        longint mg;
        longint m;
        p  = longint'($signed(a)) * longint'($signed(b));
        mg = (p < 0) ? -p : p;
        m  = mg >> 13;
        if (m == 0) return 17'd0;
        if (p > 0) begin
            if (m > 32767) return {1'b1, 16'h7fff};
            return {1'b0, m[15:0]};
        end
        if (m > 32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(-m)};
    endfunction

    task automatic push_op(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] p, input logic o);
        op_t x;
        x.a = a;
        x.b = b;
        x.p = p;
        x.o = o;
        pend.push_back(x);
    endtask

    task automatic push_model(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        r = model(a, b);
        push_op(a, b, r[15:0], r[16]);
    endtask

    task automatic push_rand();
        logic [15:0] a;
        logic [15:0] b;
        a = 16'($urandom);
        b = 16'($urandom_range(0, 16'h2fff));
        if ($urandom_range(0, 1) == 1) b = '0 - b;
        push_model(a, b);
    endtask

    always @(negedge I_CLK) begin
        if (!I_RST && O_OUT_VLD) begin
            vld_n++;
            if (sb.size() == 0) begin
                chk("spurious_vld", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("product", 32'(O_PRODUCT), 32'(mon_e.p));
                chk("ovf", 32'(O_OVF), 32'(mon_e.o));
                last_p = mon_e.p;
                last_o = mon_e.o;
            end
        end
    end

    // Drives every queued op with START held, checking latency and period.
    task automatic run_seq();
        op_t o;
        int  c0;
        int  prev;
        int  t;
        @(negedge I_CLK);
        o = pend.pop_front();
        I_MULTIPLICAND = o.a;
        I_MULTIPLIER   = o.b;
        I_MUL_START    = 1'b1;
        sb.push_back(o);
        c0   = cyc;
        prev = -1;
        forever begin
            t = 0;
            @(negedge I_CLK);
            while (!O_OUT_VLD && t < 40) begin
                @(negedge I_CLK);
                t++;
            end
            if (!O_OUT_VLD) begin
                chk("vld_timeout", 32'd0, 32'd1);
                I_MUL_START = 1'b0;
                sb.delete();
                pend.delete();
                break;
            end
            if (prev < 0) chk("latency", 32'(cyc - c0), 32'd18);
            else          chk("period", 32'(cyc - prev), 32'd19);
            prev = cyc;
            if (pend.size() == 0) begin
                I_MUL_START = 1'b0;
                break;
            end
            o = pend.pop_front();
            I_MULTIPLICAND = o.a;
            I_MULTIPLIER   = o.b;
            sb.push_back(o);
        end
    endtask

    initial begin
        int c0;
        int n0;
        I_RST          = 1'b1;
        I_MUL_START    = 1'b0;
        I_MULTIPLICAND = '0;
        I_MULTIPLIER   = '0;
        repeat (2) @(negedge I_CLK);
        chk("rst_product", 32'(O_PRODUCT), 32'd0);
        chk("rst_ovf", 32'(O_OVF), 32'd0);
        chk("rst_vld", 32'(O_OUT_VLD), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(S_IDLE));
        I_RST = 1'b0;
        @(negedge I_CLK);

        push_op(16'h3000, 16'h4000, 16'h6000, 1'b0);
        push_op(16'hd000, 16'h4000, 16'ha000, 1'b0);
        push_op(16'hffff, 16'h2000, 16'hffff, 1'b0);
        push_op(16'hffff, 16'h1000, 16'h0000, 1'b0);
        push_op(16'h7000, 16'h6000, 16'h7fff, 1'b1);
        push_op(16'h8000, 16'h8000, 16'h7fff, 1'b1);
        push_op(16'h8000, 16'h2000, 16'h8000, 1'b0);
        while (pend.size() != 0) begin
            op_t one;
            one = pend.pop_front();
            pend.push_back(one);
            run_seq();
            repeat (2) @(negedge I_CLK);
        end

        @(negedge I_CLK);
        I_MULTIPLICAND = 16'h1234;
        I_MULTIPLIER   = 16'h2345;
        I_MUL_START    = 1'b1;
        c0 = cyc;
        n0 = vld_n;
        while (cyc < c0 + 9) @(negedge I_CLK);
        I_MUL_START = 1'b0;
        @(negedge I_CLK);
        chk("abort_idle", 32'(dut.state), 32'(S_IDLE));
        repeat (25) @(negedge I_CLK);
        chk("abort_novld", 32'(vld_n), 32'(n0));
        chk("abort_hold", 32'(O_PRODUCT), 32'(last_p));

        push_model(16'h7fff, 16'h7fff);
        run_seq();
        repeat (2) @(negedge I_CLK);

        @(negedge I_CLK);
        I_MULTIPLICAND = 16'h5a5a;
        I_MULTIPLIER   = 16'h1357;
        I_MUL_START    = 1'b1;
        c0 = cyc;
        n0 = vld_n;
        while (cyc < c0 + 8) @(negedge I_CLK);
        #2 I_RST = 1'b1;
        I_MUL_START = 1'b0;
        #1;
        chk("arst_product", 32'(O_PRODUCT), 32'd0);
        chk("arst_ovf", 32'(O_OVF), 32'd0);
        chk("arst_vld", 32'(O_OUT_VLD), 32'd0);
        repeat (3) @(negedge I_CLK);
        I_RST = 1'b0;
        repeat (2) @(negedge I_CLK);
        chk("arst_novld", 32'(vld_n), 32'(n0));

        push_model(16'h2000, 16'h1800);
        for (int i = 0; i < 5; i++) push_rand();
        run_seq();

        repeat (3) @(negedge I_CLK);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
